// File: rtl/sp_rx_pkg.sv
// Shared definitions for the s_p_rx serial receiver: FSM states and default frame width.
package sp_rx_pkg;

    localparam int unsigned SpWidth = 8;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StWaitLow
    } sp_state_e;

endpackage

// File: rtl/s_p_rx_if.sv
// Serial-in / word-out bus of s_p_rx. err_cnt exists only when SP_RX_ERR_CNT_EN is defined.
interface s_p_rx_if #(
    parameter int unsigned WIDTH = sp_rx_pkg::SpWidth
);

    logic             Dbit_in;
    logic             link_S_in;
    logic [WIDTH-1:0] byte_out;
    logic             byte_valid;
    logic             byte_ready;
    logic             frame_err;
    logic             overrun;
`ifdef SP_RX_ERR_CNT_EN
    logic [7:0]       err_cnt;

    modport master (
        output Dbit_in, link_S_in, byte_ready,
        input  byte_out, byte_valid, frame_err, overrun, err_cnt
    );
    modport slave (
        input  Dbit_in, link_S_in, byte_ready,
        output byte_out, byte_valid, frame_err, overrun, err_cnt
    );
`else
    modport master (
        output Dbit_in, link_S_in, byte_ready,
        input  byte_out, byte_valid, frame_err, overrun
    );
    modport slave (
        input  Dbit_in, link_S_in, byte_ready,
        output byte_out, byte_valid, frame_err, overrun
    );
`endif

endinterface

// File: rtl/sp_out_fifo.sv
// Two-entry valid/ready output buffer; drops a push when full and not popping, flagging overrun.
module sp_out_fifo #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_overrun
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_count;
    logic             r_overrun;
    logic             w_pop;
    logic             w_full;

    assign w_full    = (r_count == 2'd2);
    assign w_pop     = (r_count != 2'd0) && i_ready;
    assign o_data    = r_head;
    assign o_valid   = (r_count != 2'd0);
    assign o_overrun = r_overrun;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= 2'd0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= i_push && w_full && !w_pop;
            unique case ({i_push, w_pop})
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= i_push_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_push_data;
                    end
                end
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head  <= i_push_data;
                        r_count <= 2'd1;
                    end else if (r_count == 2'd1) begin
                        r_tail  <= i_push_data;
                        r_count <= 2'd2;
                    end
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/s_p_rx.sv
// Serial-to-parallel receiver: framing FSM plus shift register feeding a 2-deep output buffer.
// Optional saturating error counter enabled by SP_RX_ERR_CNT_EN.
module s_p_rx
    import sp_rx_pkg::*;
#(
    parameter int unsigned WIDTH = SpWidth
) (
    input logic     clk,
    input logic     rst,
    s_p_rx_if.slave bus
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    sp_state_e        r_state;
    logic [WIDTH-2:0] r_shift;
    logic [CntW-1:0]  r_cnt;
    logic             r_frame_err;
    logic             r_xtra;
    logic             r_push;
    logic [WIDTH-1:0] r_push_data;
    logic [CntW-1:0]  w_cnt_nxt;
    logic [WIDTH-1:0] w_word;
    logic             w_overrun;

    assign w_cnt_nxt = (r_state == StShift) ? r_cnt + 1'b1 : CntW'(1);
    assign w_word    = {r_shift, bus.Dbit_in};

    // r_xtra: the current link-high run has already been flagged (or is an interrupted
    // frame's tail after reset), so further high cycles raise nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= bus.link_S_in ? StWaitLow : StIdle;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_frame_err <= 1'b0;
            r_xtra      <= 1'b1;
            r_push      <= 1'b0;
            r_push_data <= '0;
        end else begin
            r_frame_err <= 1'b0;
            r_push      <= 1'b0;
            unique case (r_state)
                StIdle, StShift: begin
                    if (bus.link_S_in) begin
                        r_shift <= w_word[WIDTH-2:0];
                        r_cnt   <= w_cnt_nxt;
                        if (w_cnt_nxt == CntW'(WIDTH)) begin
                            r_push      <= 1'b1;
                            r_push_data <= w_word;
                            r_xtra      <= 1'b0;
                            r_state     <= StWaitLow;
                        end else begin
                            r_state <= StShift;
                        end
                    end else begin
                        r_frame_err <= (r_state == StShift);
                        r_cnt       <= '0;
                        r_state     <= StIdle;
                    end
                end
                StWaitLow: begin
                    if (bus.link_S_in) begin
                        r_frame_err <= !r_xtra;
                        r_xtra      <= 1'b1;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    sp_out_fifo #(
        .WIDTH(WIDTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (r_push),
        .i_push_data(r_push_data),
        .i_ready    (bus.byte_ready),
        .o_data     (bus.byte_out),
        .o_valid    (bus.byte_valid),
        .o_overrun  (w_overrun)
    );

    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = w_overrun;

`ifdef SP_RX_ERR_CNT_EN
    logic [7:0] r_err_cnt;
    logic [8:0] w_err_sum;

    assign w_err_sum = {1'b0, r_err_cnt} + 9'(r_frame_err) + 9'(w_overrun);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= 8'd0;
        end else begin
            r_err_cnt <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
        end
    end

    assign bus.err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_s_p_rx.sv
// Bench for s_p_rx: frame vector table, directed buffer/reset sequences, random run vs a model.
module tb_s_p_rx;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    s_p_rx_if #(.WIDTH(W)) tb_bus ();

    s_p_rx #(
        .WIDTH(W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(tb_bus)
    );

    typedef struct {
        int          nbits;
        logic [15:0] bits;
        int          exp_nvalid;
        logic [7:0]  exp_byte;
        int          exp_vedge;
        int          exp_nerr;
        int          exp_eedge;
    } vec_t;

    vec_t vecs[8];

    int n_checks = 0;
    int n_err    = 0;

    // Tallies since the last mark()
    int         t_edge, t_nvalid, t_vedge, t_nerr, t_eedge, t_nov;
    logic [7:0] t_byte;

    // Reference model: link-high run length and a queue-based buffer
    bit         m_on = 1'b0;
    int         m_run;
    bit         m_taint;
    bit         m_pend;
    logic [7:0] m_pend_word;
    logic [7:0] m_word;
    logic [7:0] m_q[$];
    bit         m_fe, m_ov;
    int         m_ec;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mark();
        t_edge = 0; t_nvalid = 0; t_vedge = 0; t_nerr = 0; t_eedge = 0; t_nov = 0;
        t_byte = 8'h00;
    endtask

    task automatic model_step(input logic l, input logic d, input logic r);
        bit pop;
        m_ec = m_ec + int'(m_fe) + int'(m_ov);
        if (m_ec > 255) m_ec = 255;
        pop  = (m_q.size() > 0) && r;
        m_ov = 1'b0;
        if (pop) void'(m_q.pop_front());
        if (m_pend) begin
            if (m_q.size() < 2) m_q.push_back(m_pend_word);
            else m_ov = 1'b1;
        end
        m_pend = 1'b0;
        m_fe   = 1'b0;
        if (l) begin
            m_run++;
            m_word = {m_word[6:0], d};
            if (!m_taint) begin
                if (m_run == W) begin
                    m_pend      = 1'b1;
                    m_pend_word = m_word;
                end else if (m_run == W + 1) begin
                    m_fe = 1'b1;
                end
            end
        end else begin
            if (!m_taint && m_run > 0 && m_run < W) m_fe = 1'b1;
            m_run   = 0;
            m_taint = 1'b0;
        end
        chk("rnd_valid", 32'(tb_bus.byte_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) chk("rnd_byte", 32'(tb_bus.byte_out), 32'(m_q[0]));
        chk("rnd_frame_err", 32'(tb_bus.frame_err), 32'(m_fe));
        chk("rnd_overrun", 32'(tb_bus.overrun), 32'(m_ov));
`ifdef SP_RX_ERR_CNT_EN
        chk("rnd_err_cnt", 32'(tb_bus.err_cnt), 32'(m_ec));
`endif
    endtask

    task automatic tick(input logic l, input logic d, input logic r);
        tb_bus.link_S_in  = l;
        tb_bus.Dbit_in    = d;
        tb_bus.byte_ready = r;
        @(posedge clk);
        #1;
        t_edge++;
        if (tb_bus.byte_valid) begin
            if (t_nvalid == 0) begin
                t_vedge = t_edge;
                t_byte  = tb_bus.byte_out;
            end
            t_nvalid++;
        end
        if (tb_bus.frame_err) begin
            if (t_nerr == 0) t_eedge = t_edge;
            t_nerr++;
        end
        if (tb_bus.overrun) t_nov++;
        if (m_on) model_step(l, d, r);
    endtask

    task automatic send_bits(input int nbits, input logic [15:0] bits, input logic r);
        for (int i = nbits - 1; i >= 0; i--) tick(1'b1, bits[i], r);
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, r);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_byte_out"}, 32'(tb_bus.byte_out), 32'h0);
        chk({tag, "_byte_valid"}, 32'(tb_bus.byte_valid), 32'h0);
        chk({tag, "_frame_err"}, 32'(tb_bus.frame_err), 32'h0);
        chk({tag, "_overrun"}, 32'(tb_bus.overrun), 32'h0);
`ifdef SP_RX_ERR_CNT_EN
        chk({tag, "_err_cnt"}, 32'(tb_bus.err_cnt), 32'h0);
`endif
    endtask

    initial begin
        vecs[0] = '{8,  16'h00A5, 1, 8'hA5, 9, 0, 0};
        vecs[1] = '{5,  16'h0015, 0, 8'h00, 0, 1, 6};
        vecs[2] = '{8,  16'h003C, 1, 8'h3C, 9, 0, 0};
        vecs[3] = '{9,  16'h01FE, 1, 8'hFF, 9, 1, 9};
        vecs[4] = '{8,  16'h0000, 1, 8'h00, 9, 0, 0};
        vecs[5] = '{1,  16'h0001, 0, 8'h00, 0, 1, 2};
        vecs[6] = '{11, 16'h02D7, 1, 8'h5A, 9, 1, 9};
        vecs[7] = '{7,  16'h007F, 0, 8'h00, 0, 1, 8};

        mark();
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        chk_zero("reset");
        rst = 1'b0;
        idle(2, 1'b1);

        // Single frames with byte_ready held high
        for (int v = 0; v < 8; v++) begin
            mark();
            send_bits(vecs[v].nbits, vecs[v].bits, 1'b1);
            idle(4, 1'b1);
            chk($sformatf("vec%0d_nvalid", v), 32'(t_nvalid), 32'(vecs[v].exp_nvalid));
            if (vecs[v].exp_nvalid > 0) begin
                chk($sformatf("vec%0d_byte", v), 32'(t_byte), 32'(vecs[v].exp_byte));
                chk($sformatf("vec%0d_vedge", v), 32'(t_vedge), 32'(vecs[v].exp_vedge));
            end
            chk($sformatf("vec%0d_nerr", v), 32'(t_nerr), 32'(vecs[v].exp_nerr));
            chk($sformatf("vec%0d_eedge", v), 32'(t_eedge), 32'(vecs[v].exp_eedge));
            chk($sformatf("vec%0d_nov", v), 32'(t_nov), 32'h0);
        end

        // Three frames into a stalled buffer: the third overruns
        mark();
        send_bits(8, 16'h0011, 1'b0); idle(1, 1'b0);
        send_bits(8, 16'h0022, 1'b0); idle(1, 1'b0);
        send_bits(8, 16'h0033, 1'b0); idle(3, 1'b0);
        chk("ovr_count", 32'(t_nov), 32'h1);
        chk("ovr_head_valid", 32'(tb_bus.byte_valid), 32'h1);
        chk("ovr_head0", 32'(tb_bus.byte_out), 32'h11);
        tick(1'b0, 1'b0, 1'b1);
        chk("ovr_head1", 32'(tb_bus.byte_out), 32'h22);
        chk("ovr_valid1", 32'(tb_bus.byte_valid), 32'h1);
        tick(1'b0, 1'b0, 1'b1);
        chk("ovr_drained", 32'(tb_bus.byte_valid), 32'h0);

        // Full buffer, pop on the very cycle the next word lands
        mark();
        send_bits(8, 16'h0011, 1'b0); idle(1, 1'b0);
        send_bits(8, 16'h0022, 1'b0); idle(1, 1'b0);
        send_bits(8, 16'h0044, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        chk("pp_head", 32'(tb_bus.byte_out), 32'h22);
        tick(1'b0, 1'b0, 1'b0);
        chk("pp_hold", 32'(tb_bus.byte_out), 32'h22);
        chk("pp_hold_valid", 32'(tb_bus.byte_valid), 32'h1);
        tick(1'b0, 1'b0, 1'b1);
        chk("pp_second", 32'(tb_bus.byte_out), 32'h44);
        tick(1'b0, 1'b0, 1'b1);
        chk("pp_drained", 32'(tb_bus.byte_valid), 32'h0);
        chk("pp_no_overrun", 32'(t_nov), 32'h0);
`ifdef SP_RX_ERR_CNT_EN
        chk("errcnt_before_rst", 32'(tb_bus.err_cnt), 32'd6);
`endif

        // Reset mid-frame with a buffered word and link held through release
        send_bits(8, 16'h0077, 1'b0); idle(2, 1'b0);
        send_bits(4, 16'h000A, 1'b0);
        rst = 1'b1;
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        chk_zero("midrst");
        rst = 1'b0;
        mark();
        send_bits(4, 16'h0005, 1'b1);
        idle(3, 1'b1);
        chk("midrst_tail_err", 32'(t_nerr), 32'h0);
        chk("midrst_tail_valid", 32'(t_nvalid), 32'h0);
        mark();
        send_bits(8, 16'h005A, 1'b1);
        idle(4, 1'b1);
        chk("midrst_next_nvalid", 32'(t_nvalid), 32'h1);
        chk("midrst_next_byte", 32'(t_byte), 32'h5A);
        chk("midrst_next_nerr", 32'(t_nerr), 32'h0);

        // Random frames, gaps and back-pressure against the model
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        m_run = 0; m_taint = 1'b0; m_pend = 1'b0; m_word = 8'h00;
        m_fe = 1'b0; m_ov = 1'b0; m_ec = 0;
        m_q.delete();
        m_on = 1'b1;
        for (int f = 0; f < 250; f++) begin
            int len;
            int gap;
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 11)) : 8;
            gap = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3));
            for (int b = 0; b < len; b++) begin
                tick(1'b1, 1'($urandom), 1'($urandom_range(0, 9) < 6));
            end
            for (int g = 0; g < gap; g++) begin
                tick(1'b0, 1'($urandom), 1'($urandom_range(0, 9) < 6));
            end
        end
        idle(6, 1'b1);
        m_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
